// File: rtl/stream_pool.sv
// Streaming per-lane pooling engine: reduces LANES independent elements over a
// window of 1..MAX_WIN beats (max, min or saturating sum), one result per window.
module stream_pool #(
  parameter int DATA_W  = 32,
  parameter int LANES   = 4,
  parameter int MAX_WIN = 16,
  parameter int SIGNED  = 1,
  parameter int CNT_W   = $clog2(MAX_WIN + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              cfg_mode,
  input  logic [CNT_W-1:0]        cfg_win,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]        out_beats,
  output logic [LANES-1:0]        out_sat
);

  localparam int ACC_W = DATA_W + CNT_W;
  localparam logic [CNT_W-1:0] MAX_WIN_C = CNT_W'(MAX_WIN);

  typedef enum logic [1:0] {
    MODE_MAX = 2'd0,
    MODE_MIN = 2'd1,
    MODE_SUM = 2'd2
  } mode_e;

  // The emit step is the closing edge itself, so only two states are stored.
  typedef enum logic {
    IDLE,
    ACC
  } state_e;

  state_e                         state, state_nxt;
  logic [1:0]                     mode_q, mode_cur;
  logic [CNT_W-1:0]               win_q, win_cur;
  logic [CNT_W-1:0]               cnt_q, cnt_nxt;
  logic [LANES-1:0][ACC_W-1:0]    acc_q, acc_nxt;
  logic [LANES*DATA_W-1:0]        res_data;
  logic [LANES-1:0]               res_sat;
  logic                           first, accept, close;

  function automatic logic [ACC_W-1:0] ext(input logic [DATA_W-1:0] x);
    if (SIGNED != 0) return {{CNT_W{x[DATA_W-1]}}, x};
    else             return {{CNT_W{1'b0}}, x};
  endfunction

  function automatic logic less(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
    if (SIGNED != 0) return $signed(a) < $signed(b);
    else             return a < b;
  endfunction

  function automatic logic [ACC_W-1:0] reduce(input logic [1:0] mode,
                                              input logic [ACC_W-1:0] acc,
                                              input logic [ACC_W-1:0] x);
    case (mode)
      MODE_SUM: return acc + x;
      MODE_MIN: return less(x, acc) ? x : acc;
      default:  return less(acc, x) ? x : acc;  // max, and reserved mode 3
    endcase
  endfunction

  // Returns {sat, value} with the wide sum clamped into the DATA_W range.
  function automatic logic [DATA_W:0] clamp(input logic [ACC_W-1:0] s);
    logic hi, lo;
    if (SIGNED != 0) begin
      hi = !s[ACC_W-1] &&  (|s[ACC_W-2:DATA_W-1]);
      lo =  s[ACC_W-1] && !(&s[ACC_W-2:DATA_W-1]);
      if (hi)      return {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
      else if (lo) return {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
      else         return {1'b0, s[DATA_W-1:0]};
    end else begin
      hi = |s[ACC_W-1:DATA_W];
      if (hi) return {1'b1, {DATA_W{1'b1}}};
      else    return {1'b0, s[DATA_W-1:0]};
    end
  endfunction

  assign in_ready = !out_valid || out_ready;

  // NOTE: every signal driven here gets a default at the top of the block,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    first     = (state == IDLE);
    accept    = in_valid && in_ready;
    mode_cur  = first ? cfg_mode : mode_q;
    win_cur   = win_q;
    if (first) begin
      win_cur = (cfg_win == '0 || cfg_win > MAX_WIN_C) ? MAX_WIN_C : cfg_win;
    end
    cnt_nxt   = first ? CNT_W'(1) : cnt_q + CNT_W'(1);
    close     = accept && (in_last || cnt_nxt >= win_cur);
    acc_nxt   = acc_q;
    res_data  = '0;
    res_sat   = '0;

    for (int k = 0; k < LANES; k++) begin
      if (first) acc_nxt[k] = ext(in_data[k*DATA_W +: DATA_W]);
      else       acc_nxt[k] = reduce(mode_cur, acc_q[k], ext(in_data[k*DATA_W +: DATA_W]));
      if (mode_cur == MODE_SUM) begin
        {res_sat[k], res_data[k*DATA_W +: DATA_W]} = clamp(acc_nxt[k]);
      end else begin
        res_data[k*DATA_W +: DATA_W] = acc_nxt[k][DATA_W-1:0];
      end
    end

    if (accept) state_nxt = close ? IDLE : ACC;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      // NOTE: the accumulators are reset too, so an abandoned window can never
      // leak into the next result.
      acc_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
      out_sat   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mode_q <= mode_cur;
        win_q  <= win_cur;
        acc_q  <= acc_nxt;
        cnt_q  <= close ? '0 : cnt_nxt;
      end
      if (close) begin
        out_valid <= 1'b1;
        out_data  <= res_data;
        out_beats <= cnt_nxt;
        out_sat   <= res_sat;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_pool.sv
// Directed bench for stream_pool: a signed and an unsigned instance share one
// stimulus stream; every expected value below is hand-computed.
module tb_stream_pool;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   cfg_mode;
  logic [4:0]   cfg_win;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [4:0]   out_beats;
  logic [3:0]   out_sat;

  logic         u_in_ready;
  logic         u_out_valid;
  logic [127:0] u_out_data;
  logic [4:0]   u_out_beats;
  logic [3:0]   u_out_sat;

  int checks = 0;
  int errors = 0;

  stream_pool #(.DATA_W(32), .LANES(4), .MAX_WIN(16), .SIGNED(1)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_win(cfg_win),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_beats(out_beats), .out_sat(out_sat)
  );

  stream_pool #(.DATA_W(32), .LANES(4), .MAX_WIN(16), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_win(cfg_win),
    .in_valid(in_valid), .in_ready(u_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(u_out_valid), .out_ready(out_ready), .out_data(u_out_data),
    .out_beats(u_out_beats), .out_sat(u_out_sat)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pk(input logic [31:0] l0, input logic [31:0] l1,
                                      input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one beat and holds it until accepted (bounded wait).
  task automatic beat(input logic [127:0] d, input logic last);
    bit done;
    done     = 1'b0;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      done = in_ready;
      @(posedge clk);
      #1;
    end
    check("beat_accepted", {127'd0, done}, 128'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    cfg_mode  = 2'd0;
    cfg_win   = 5'd4;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    #3;
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_out_data",  out_data, 128'd0);
    check("rst_out_beats", {123'd0, out_beats}, 128'd0);
    check("rst_out_sat",   {124'd0, out_sat}, 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);

    // Max, window 4
    cfg_mode = 2'd0;
    cfg_win  = 5'd4;
    beat(pk(32'd5,          32'd1, 32'hFFFF_FFFF, 32'd0), 1'b0);
    beat(pk(32'hFFFF_FFFD,  32'd2, 32'hFFFF_FFFE, 32'd0), 1'b0);
    beat(pk(32'd12,         32'd3, 32'hFFFF_FFFD, 32'd0), 1'b0);
    check("max_not_early", {127'd0, out_valid}, 128'd0);
    beat(pk(32'd7,          32'd4, 32'hFFFF_FFFC, 32'd0), 1'b0);
    check("max_valid", {127'd0, out_valid}, 128'd1);
    check("max_data",  out_data, pk(32'd12, 32'd4, 32'hFFFF_FFFF, 32'd0));
    check("max_beats", {123'd0, out_beats}, 128'd4);
    check("max_sat",   {124'd0, out_sat}, 128'd0);
    check("max_u_data", u_out_data, pk(32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFFF, 32'd0));
    idle(1);
    check("max_drained", {127'd0, out_valid}, 128'd0);

    // Min, window 2: unsigned vs signed
    cfg_mode = 2'd1;
    cfg_win  = 5'd2;
    beat(pk(32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0), 1'b0);
    beat(pk(32'd1,         32'd0, 32'd0, 32'd0), 1'b0);
    check("min_s_data",  out_data,   pk(32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0));
    check("min_u_data",  u_out_data, pk(32'd1, 32'd0, 32'd0, 32'd0));
    check("min_s_beats", {123'd0, out_beats}, 128'd2);

    // Saturating sum, window 2
    cfg_mode = 2'd2;
    cfg_win  = 5'd2;
    beat(pk(32'h7FFF_FFFF, 32'hFFFF_FFFB, 32'h8000_0000, 32'd10), 1'b0);
    beat(pk(32'd1,         32'd3,         32'hFFFF_FFFF, 32'd20), 1'b0);
    check("sum_s_data", out_data, pk(32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0000, 32'd30));
    check("sum_s_sat",  {124'd0, out_sat}, 128'h5);
    check("sum_u_data", u_out_data, pk(32'h8000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd30));
    check("sum_u_sat",  {124'd0, u_out_sat}, 128'h4);
    idle(1);
    check("sum_drained", {127'd0, out_valid}, 128'd0);

    // Backpressure: result held for 5 cycles, next first beat waits
    out_ready = 1'b0;
    cfg_mode  = 2'd0;
    cfg_win   = 5'd2;
    beat(pk(32'd3, 32'd0, 32'd0, 32'd0), 1'b0);
    beat(pk(32'd9, 32'd0, 32'd0, 32'd0), 1'b0);
    in_data  = pk(32'd100, 32'd0, 32'd0, 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",    {127'd0, out_valid}, 128'd1);
      check("bp_in_ready", {127'd0, in_ready}, 128'd0);
      check("bp_data",     out_data, pk(32'd9, 32'd0, 32'd0, 32'd0));
      check("bp_beats",    {123'd0, out_beats}, 128'd2);
      idle(1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {127'd0, in_ready}, 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_drained", {127'd0, out_valid}, 128'd0);
    beat(pk(32'd50, 32'd0, 32'd0, 32'd0), 1'b0);
    check("bp_next_data",  out_data, pk(32'd100, 32'd0, 32'd0, 32'd0));
    check("bp_next_beats", {123'd0, out_beats}, 128'd2);

    // Early close via in_last with an input gap mid-window
    cfg_mode = 2'd2;
    cfg_win  = 5'd8;
    beat(pk(32'd1, 32'd0, 32'd0, 32'd0), 1'b0);
    idle(3);
    check("gap_open", {127'd0, out_valid}, 128'd0);
    beat(pk(32'd2, 32'd0, 32'd0, 32'd0), 1'b0);
    beat(pk(32'd3, 32'd0, 32'd0, 32'd0), 1'b1);
    check("last_valid", {127'd0, out_valid}, 128'd1);
    check("last_data",  out_data, pk(32'd6, 32'd0, 32'd0, 32'd0));
    check("last_beats", {123'd0, out_beats}, 128'd3);

    // cfg_win = 0 means MAX_WIN; mid-window cfg changes are ignored
    cfg_mode = 2'd2;
    cfg_win  = 5'd0;
    for (int i = 0; i < 16; i++) begin
      beat(pk(32'(i + 1), 32'd0, 32'd0, 32'd0), 1'b0);
      if (i == 0) begin
        cfg_mode = 2'd1;
        cfg_win  = 5'd2;
      end
      if (i == 14) check("win16_open", {127'd0, out_valid}, 128'd0);
    end
    check("win16_valid", {127'd0, out_valid}, 128'd1);
    check("win16_data",  out_data, pk(32'd136, 32'd0, 32'd0, 32'd0));
    check("win16_beats", {123'd0, out_beats}, 128'd16);

    // in_last on the first beat gives a 1-beat pass-through
    cfg_mode = 2'd0;
    cfg_win  = 5'd4;
    beat(pk(32'hDEAD_BEEF, 32'h1234_5678, 32'h8000_0000, 32'd7), 1'b1);
    check("one_valid", {127'd0, out_valid}, 128'd1);
    check("one_data",  out_data, pk(32'hDEAD_BEEF, 32'h1234_5678, 32'h8000_0000, 32'd7));
    check("one_beats", {123'd0, out_beats}, 128'd1);

    // Reset mid-window discards the partial window
    cfg_mode = 2'd0;
    cfg_win  = 5'd4;
    beat(pk(32'd1000, 32'd0, 32'd0, 32'd0), 1'b0);
    beat(pk(32'd2000, 32'd0, 32'd0, 32'd0), 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {127'd0, out_valid}, 128'd0);
    check("mid_rst_data",  out_data, 128'd0);
    idle(2);
    rst = 1'b0;
    idle(1);
    check("post_rst_valid", {127'd0, out_valid}, 128'd0);
    beat(pk(32'd1, 32'd0, 32'd0, 32'd0), 1'b0);
    beat(pk(32'd2, 32'd0, 32'd0, 32'd0), 1'b0);
    check("post_rst_open", {127'd0, out_valid}, 128'd0);
    beat(pk(32'd3, 32'd0, 32'd0, 32'd0), 1'b0);
    beat(pk(32'd4, 32'd0, 32'd0, 32'd0), 1'b0);
    check("post_rst_data",  out_data, pk(32'd4, 32'd0, 32'd0, 32'd0));
    check("post_rst_beats", {123'd0, out_beats}, 128'd4);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
